// File: rtl/line_pkg.sv
// Shared types for the line segment sequencer: the buffered point record,
// sequencer states, default display size and coordinate clamp helpers.
package line_pkg;

    localparam int H_ACTIVE_DEFAULT = 800;
    localparam int V_ACTIVE_DEFAULT = 480;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic        pen_up;
    } point_t;

    typedef enum logic [1:0] {IDLE, START, WAIT} seq_state_t;

    function automatic logic [10:0] clamp_x(input logic [10:0] x, input int h_active);
        return (int'(x) > h_active - 1) ? 11'(h_active - 1) : x;
    endfunction

    function automatic logic [9:0] clamp_y(input logic [9:0] y, input int v_active);
        return (int'(y) > v_active - 1) ? 10'(v_active - 1) : y;
    endfunction

endpackage

// File: rtl/line_segment_sequencer_if.sv
// Point stream in and segment command out of the line segment sequencer.
// The sequencer uses the slave modport; the point source and drawer sit on master.
interface line_segment_sequencer_if;

    logic        pt_valid;
    logic [10:0] pt_x;
    logic [9:0]  pt_y;
    logic        pt_pen_up;
    logic        pt_ready;
    logic [10:0] x_offset;
    logic [9:0]  y_offset;
    logic [10:0] x_final;
    logic [9:0]  y_final;
    logic        start_mark;
    logic        done_mark;
    logic        busy;

    modport slave (
        input  pt_valid, pt_x, pt_y, pt_pen_up, done_mark,
        output pt_ready, x_offset, y_offset, x_final, y_final, start_mark, busy
    );

    modport master (
        output pt_valid, pt_x, pt_y, pt_pen_up, done_mark,
        input  pt_ready, x_offset, y_offset, x_final, y_final, start_mark, busy
    );

endinterface

// File: rtl/point_fifo.sv
// Synchronous show-ahead FIFO of points; the head entry is visible on pop_data
// whenever the FIFO is not empty. DEPTH must be a power of two.
module point_fifo
    import line_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  point_t                 push_data,
    input  logic                   pop,
    output point_t                 pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    point_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/line_segment_sequencer.sv
// Turns a buffered stream of stroke points into start/end segments for the line drawer.
// Define LINESEQ_WATCHDOG_EN to abort a segment whose done_mark never arrives.
module line_segment_sequencer
    import line_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int H_ACTIVE   = H_ACTIVE_DEFAULT,
    parameter int V_ACTIVE   = V_ACTIVE_DEFAULT,
    parameter int TIMEOUT    = 2000000
) (
    input  logic                        clk,
    input  logic                        reset,
    line_segment_sequencer_if.slave     bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        seg_error
);

    seq_state_t  state;
    seq_state_t  state_next;
    point_t      in_pt;
    point_t      head;
    logic [10:0] last_x;
    logic [9:0]  last_y;
    logic        last_valid;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        draw;
    logic        timeout;

    assign in_pt = '{x:      clamp_x(bus.pt_x, H_ACTIVE),
                     y:      clamp_y(bus.pt_y, V_ACTIVE),
                     pen_up: bus.pt_pen_up};

    assign bus.pt_ready = !fifo_full;
    assign pop          = (state == IDLE) && !fifo_empty;
    assign draw         = !head.pen_up && last_valid &&
                          ((head.x != last_x) || (head.y != last_y));
    assign bus.busy     = (state != IDLE);

    point_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.pt_valid),
        .push_data (in_pt),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next     = state;
        bus.start_mark = 1'b0;
        unique case (state)
            IDLE:    if (pop && draw) state_next = START;
            START: begin
                bus.start_mark = 1'b1;
                state_next     = WAIT;
            end
            WAIT:    if (bus.done_mark || timeout) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Every popped point becomes the new anchor, whether or not it draws
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_x       <= '0;
            last_y       <= '0;
            last_valid   <= 1'b0;
            bus.x_offset <= '0;
            bus.y_offset <= '0;
            bus.x_final  <= '0;
            bus.y_final  <= '0;
        end else if (pop) begin
            last_x     <= head.x;
            last_y     <= head.y;
            last_valid <= 1'b1;
            if (draw) begin
                bus.x_offset <= last_x;
                bus.y_offset <= last_y;
                bus.x_final  <= head.x;
                bus.y_final  <= head.y;
            end
        end
    end

`ifdef LINESEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_count;

    assign timeout = (state == WAIT) && (wd_count == WD_W'(TIMEOUT - 1));

    // Counts consecutive WAIT cycles; done_mark in the same cycle wins over timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_count  <= '0;
            seg_error <= 1'b0;
        end else begin
            if (state == WAIT && state_next == WAIT) wd_count <= wd_count + 1'b1;
            else                                     wd_count <= '0;
            if (timeout && !bus.done_mark) seg_error <= 1'b1;
        end
    end
`else
    assign timeout   = 1'b0;
    assign seg_error = 1'b0;
`endif

endmodule

// File: tb/tb_line_segment_sequencer.sv
// Self-checking bench for line_segment_sequencer: a drawer model answers start_mark,
// and a point-level reference model predicts the segment stream.
`timescale 1ns/1ps
module tb_line_segment_sequencer;
    import line_pkg::*;

    localparam int FIFO_DEPTH = 8;
    localparam int TIMEOUT    = 50;
    localparam int H_MAX      = 799;
    localparam int V_MAX      = 479;

    typedef struct packed {
        logic [10:0] x0;
        logic [9:0]  y0;
        logic [10:0] x1;
        logic [9:0]  y1;
    } seg_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic seg_error;

    line_segment_sequencer_if bus();

    line_segment_sequencer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .H_ACTIVE   (800),
        .V_ACTIVE   (480),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .fifo_level (fifo_level),
        .seg_error  (seg_error)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int   n_checks = 0;
    int   n_pass   = 0;
    seg_t exp_q[$];
    seg_t obs_q[$];
    int   m_last_x = 0;
    int   m_last_y = 0;
    bit   m_valid  = 1'b0;
    int   accept_cycle = 0;

    int drawer_delay = 5;
    bit drawer_hold  = 1'b0;
    bit early_done   = 1'b0;
    int start_count  = 0;
    int start_cycle  = 0;
    int done_cycle   = -10;
    int hold_bad     = 0;
    int gap_bad      = 0;
    int early_bad    = 0;

    // Reference: segments follow from the point sequence alone
    function automatic void model_push(input int x, input int y, input bit pen);
        int   cx;
        int   cy;
        seg_t s;
        cx = (x > H_MAX) ? H_MAX : x;
        cy = (y > V_MAX) ? V_MAX : y;
        if (!pen && m_valid && !(cx == m_last_x && cy == m_last_y)) begin
            s.x0 = 11'(m_last_x);
            s.y0 = 10'(m_last_y);
            s.x1 = 11'(cx);
            s.y1 = 10'(cy);
            exp_q.push_back(s);
        end
        m_last_x = cx;
        m_last_y = cy;
        m_valid  = 1'b1;
    endfunction

    // Drawer: captures each segment, checks it is held, then answers with done_mark
    initial begin
        seg_t s;
        bus.done_mark = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && bus.start_mark) begin
                s = '{x0: bus.x_offset, y0: bus.y_offset, x1: bus.x_final, y1: bus.y_final};
                obs_q.push_back(s);
                start_count++;
                start_cycle = cycle;
                if (cycle <= done_cycle) gap_bad++;
                if (early_done) begin
                    bus.done_mark = 1'b1;
                    @(negedge clk);
                    bus.done_mark = 1'b0;
                    if (!bus.busy || bus.start_mark) early_bad++;
                end
                while (drawer_hold && !reset) @(negedge clk);
                for (int i = 0; i < drawer_delay && !reset; i++) begin
                    @(negedge clk);
                    if (!reset && (!bus.busy ||
                        {bus.x_offset, bus.y_offset, bus.x_final, bus.y_final} !== s))
                        hold_bad++;
                end
                if (!reset) begin
                    bus.done_mark = 1'b1;
                    done_cycle    = cycle;
                    @(negedge clk);
                    bus.done_mark = 1'b0;
                end
            end
        end
    end

    task automatic push_point(input int x, input int y, input bit pen);
        bit rdy;
        int n;
        @(negedge clk);
        bus.pt_valid  = 1'b1;
        bus.pt_x      = 11'(x);
        bus.pt_y      = 10'(y);
        bus.pt_pen_up = pen;
        n = 0;
        forever begin
            rdy = bus.pt_ready;
            @(posedge clk);
            if (rdy) break;
            n++;
            if (n > 500) begin
                n_checks++;
                $display("[TB] FAIL push_timeout: point (%0d,%0d) not accepted after %0d cycles, expected acceptance", x, y, n);
                break;
            end
            @(negedge clk);
        end
        if (rdy) begin
            model_push(x, y, pen);
            // cycle's own update to this edge is still pending here
            accept_cycle = cycle + 1;
        end
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        bus.pt_valid = 1'b0;
    endtask

    task automatic wait_drain(input int bound, output bit ok);
        int quiet;
        quiet = 0;
        for (int i = 0; i < bound && quiet < 4; i++) begin
            @(negedge clk);
            if (!bus.busy && fifo_level == 0 && !bus.pt_valid && !bus.done_mark) quiet++;
            else quiet = 0;
        end
        ok = (quiet >= 4);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.pt_ready !== 1'b1) $display("[TB] FAIL reset_pt_ready: got %b, expected 1", bus.pt_ready); else n_pass++;
        n_checks++;
        if ({bus.start_mark, bus.busy} !== 2'b00) $display("[TB] FAIL reset_ctrl: start/busy got %b, expected 00", {bus.start_mark, bus.busy}); else n_pass++;
        n_checks++;
        if (fifo_level !== '0) $display("[TB] FAIL reset_level: got %0d, expected 0", fifo_level); else n_pass++;
        n_checks++;
        if ({bus.x_offset, bus.y_offset, bus.x_final, bus.y_final} !== 42'h0)
            $display("[TB] FAIL reset_coords: got %h, expected 0", {bus.x_offset, bus.y_offset, bus.x_final, bus.y_final});
        else n_pass++;
        n_checks++;
        if (seg_error !== 1'b0) $display("[TB] FAIL reset_seg_error: got %b, expected 0", seg_error); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_segment();
        bit ok;
        hold_bad     = 0;
        drawer_delay = 20;
        push_point(15, 0, 1'b1);
        push_point(10, 9, 1'b0);
        idle_inputs();
        wait_drain(500, ok);
        n_checks++;
        if (ok !== 1'b1) $display("[TB] FAIL single_drain: got busy/level stuck, expected drained"); else n_pass++;
        n_checks++;
        // accept edge, pop edge, then START: observed one counted cycle after acceptance
        if (start_cycle !== accept_cycle + 1) $display("[TB] FAIL single_latency: start in cycle %0d, expected %0d", start_cycle, accept_cycle + 1); else n_pass++;
        n_checks++;
        if (hold_bad !== 0) $display("[TB] FAIL single_hold: %0d unstable cycles, expected 0", hold_bad); else n_pass++;
        n_checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== seg_t'({11'd15, 10'd0, 11'd10, 10'd9}))
            $display("[TB] FAIL single_seg: got %0d segs first %h, expected 1 seg %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, seg_t'({11'd15, 10'd0, 11'd10, 10'd9}));
        else n_pass++;
        n_checks++;
        if (exp_q.size() !== 1 || obs_q.size() < 1 || obs_q[0] !== exp_q[0])
            $display("[TB] FAIL single_model: got %0d segs, expected %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        bit ok;
        gap_bad      = 0;
        hold_bad     = 0;
        drawer_delay = $urandom_range(1, 8);
        push_point(3, 0, 1'b1);
        push_point(12, 4, 1'b0);
        push_point(20, 20, 1'b0);
        idle_inputs();
        wait_drain(500, ok);
        n_checks++;
        if (ok !== 1'b1) $display("[TB] FAIL b2b_drain: got stuck, expected drained"); else n_pass++;
        n_checks++;
        if (obs_q.size() !== 2) $display("[TB] FAIL b2b_count: got %0d segments, expected 2", obs_q.size()); else n_pass++;
        n_checks++;
        if (obs_q.size() < 2 || obs_q[1] !== seg_t'({11'd12, 10'd4, 11'd20, 10'd20}))
            $display("[TB] FAIL b2b_second: got %h, expected %h", (obs_q.size() > 1) ? obs_q[1] : '0, seg_t'({11'd12, 10'd4, 11'd20, 10'd20}));
        else n_pass++;
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
                $display("[TB] FAIL b2b_seg%0d: got %h, expected %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (gap_bad !== 0 || hold_bad !== 0) $display("[TB] FAIL b2b_timing: gap errors %0d hold errors %0d, expected 0 and 0", gap_bad, hold_bad); else n_pass++;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_fifo_full();
        bit ok;
        drawer_hold  = 1'b1;
        drawer_delay = 3;
        for (int i = 0; i < 10; i++)
            push_point(i * 70 + int'($urandom_range(0, 60)), int'($urandom_range(0, 600)), (i == 0));
        fork
            push_point(777, 300, 1'b0);
            begin
                repeat (3) @(negedge clk);
                n_checks++;
                if (fifo_level !== 4'(FIFO_DEPTH)) $display("[TB] FAIL full_level: got %0d, expected %0d", fifo_level, FIFO_DEPTH); else n_pass++;
                n_checks++;
                if (bus.pt_ready !== 1'b0) $display("[TB] FAIL full_ready: got %b, expected 0", bus.pt_ready); else n_pass++;
                drawer_hold = 1'b0;
            end
        join
        idle_inputs();
        wait_drain(1000, ok);
        n_checks++;
        if (ok !== 1'b1) $display("[TB] FAIL full_drain: got stuck, expected drained"); else n_pass++;
        n_checks++;
        if (obs_q.size() !== 10) $display("[TB] FAIL full_count: got %0d segments, expected 10", obs_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
                $display("[TB] FAIL full_seg%0d: got %h, expected %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            else n_pass++;
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_clamp();
        bit ok;
        drawer_delay = 4;
        push_point(0, 0, 1'b1);
        push_point(900, 600, 1'b0);
        idle_inputs();
        wait_drain(500, ok);
        n_checks++;
        if (obs_q.size() !== 1 || obs_q[0].x1 !== 11'd799 || obs_q[0].y1 !== 10'd479)
            $display("[TB] FAIL clamp_final: got %0d segs final (%0d,%0d), expected 1 seg (799,479)", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0].x1 : 11'd0, (obs_q.size() > 0) ? obs_q[0].y1 : 10'd0);
        else n_pass++;
        n_checks++;
        if (exp_q.size() !== 1 || obs_q.size() < 1 || obs_q[0] !== exp_q[0])
            $display("[TB] FAIL clamp_model: got %0d segs, expected %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_degenerate_early_done();
        bit ok;
        int n0;
        n0 = start_count;
        push_point(5, 5, 1'b1);
        push_point(5, 5, 1'b0);
        idle_inputs();
        repeat (10) @(negedge clk);
        n_checks++;
        if (start_count !== n0) $display("[TB] FAIL degenerate_start: got %0d start_marks, expected 0", start_count - n0); else n_pass++;
        early_done   = 1'b1;
        early_bad    = 0;
        drawer_delay = 6;
        push_point(9, 7, 1'b0);
        idle_inputs();
        wait_drain(500, ok);
        early_done = 1'b0;
        n_checks++;
        if (early_bad !== 0) $display("[TB] FAIL early_done_ignored: got %0d early exits from WAIT, expected 0", early_bad); else n_pass++;
        n_checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== seg_t'({11'd5, 10'd5, 11'd9, 10'd7}))
            $display("[TB] FAIL early_done_seg: got %0d segs first %h, expected 1 seg %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, seg_t'({11'd5, 10'd5, 11'd9, 10'd7}));
        else n_pass++;
        n_checks++;
        if (exp_q.size() !== obs_q.size()) $display("[TB] FAIL early_done_model: got %0d segs, expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        bit ok;
        int x;
        int y;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) != 0) begin
                x = int'($urandom_range(0, 1100));
                y = int'($urandom_range(0, 650));
            end
            drawer_delay = $urandom_range(1, 12);
            push_point(x, y, ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 2) == 0) idle_inputs();
        end
        idle_inputs();
        wait_drain(5000, ok);
        n_checks++;
        if (ok !== 1'b1) $display("[TB] FAIL random_drain: got stuck, expected drained"); else n_pass++;
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("[TB] FAIL random_count: got %0d segments, expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
                $display("[TB] FAIL random_seg%0d: got %h, expected %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            else n_pass++;
        end
        obs_q.delete();
        exp_q.delete();
    endtask

`ifdef LINESEQ_WATCHDOG_EN
    task automatic test_watchdog();
        bit ok;
        int n;
        drawer_hold  = 1'b1;
        drawer_delay = 3;
        push_point(0, 0, 1'b1);
        push_point(60, 60, 1'b0);
        idle_inputs();
        n = 0;
        while (!bus.start_mark && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (TIMEOUT) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1) $display("[TB] FAIL wd_early: busy got %b in last WAIT cycle, expected 1", bus.busy); else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, seg_error} !== 2'b01) $display("[TB] FAIL wd_fire: busy/seg_error got %b, expected 01", {bus.busy, seg_error}); else n_pass++;
        drawer_hold = 1'b0;
        repeat (20) @(negedge clk);
        obs_q.delete();
        exp_q.delete();
        push_point(100, 100, 1'b0);
        idle_inputs();
        wait_drain(500, ok);
        n_checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== seg_t'({11'd60, 10'd60, 11'd100, 10'd100}) || seg_error !== 1'b1)
            $display("[TB] FAIL wd_sticky: got %0d segs seg_error %b, expected 1 seg (60,60)->(100,100) and 1", obs_q.size(), seg_error);
        else n_pass++;
        obs_q.delete();
        exp_q.delete();
    endtask
`endif

    task automatic test_reset_mid_segment();
        int n0;
        int n;
        bit ok;
        drawer_hold  = 1'b1;
        drawer_delay = 3;
        push_point(1, 1, 1'b1);
        push_point(40, 30, 1'b0);
        push_point(41, 31, 1'b0);
        push_point(42, 32, 1'b0);
        idle_inputs();
        n = 0;
        while (!bus.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.busy, bus.start_mark, bus.pt_ready} !== 3'b001) $display("[TB] FAIL midreset_ctrl: busy/start/ready got %b, expected 001", {bus.busy, bus.start_mark, bus.pt_ready}); else n_pass++;
        n_checks++;
        if (fifo_level !== '0) $display("[TB] FAIL midreset_level: got %0d, expected 0", fifo_level); else n_pass++;
        n_checks++;
        if ({bus.x_offset, bus.y_offset, bus.x_final, bus.y_final, seg_error} !== 43'h0)
            $display("[TB] FAIL midreset_outputs: got %h, expected 0", {bus.x_offset, bus.y_offset, bus.x_final, bus.y_final, seg_error});
        else n_pass++;
        @(negedge clk);
        drawer_hold = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_valid  = 1'b0;
        m_last_x = 0;
        m_last_y = 0;
        obs_q.delete();
        exp_q.delete();
        n0 = start_count;
        push_point(50, 50, 1'b0);
        idle_inputs();
        repeat (10) @(negedge clk);
        n_checks++;
        if (start_count !== n0) $display("[TB] FAIL midreset_no_draw: got %0d start_marks, expected 0", start_count - n0); else n_pass++;
        push_point(70, 70, 1'b0);
        idle_inputs();
        wait_drain(500, ok);
        n_checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== seg_t'({11'd50, 10'd50, 11'd70, 10'd70}) || exp_q.size() !== 1)
            $display("[TB] FAIL midreset_resume: got %0d segs first %h, expected 1 seg %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, seg_t'({11'd50, 10'd50, 11'd70, 10'd70}));
        else n_pass++;
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bus.pt_valid  = 1'b0;
        bus.pt_x      = '0;
        bus.pt_y      = '0;
        bus.pt_pen_up = 1'b0;
        $display("[TB] line_segment_sequencer bench start");
        test_reset();
        test_single_segment();
        test_back_to_back();
        test_fifo_full();
        test_clamp();
        test_degenerate_early_done();
        test_random();
`ifdef LINESEQ_WATCHDOG_EN
        test_watchdog();
`endif
        test_reset_mid_segment();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/line_segment_sequencer.md
Name: line_segment_sequencer

Overview:
- Upstream feeder for the oblique-line drawer.
- Buffers a stream of touch/stroke points in a small FIFO and turns consecutive points into line segments (x_offset,y_offset)->(x_final,y_final).
- Issues one start_mark pulse per segment, then holds the coordinates until the drawer returns done_mark.
- Pen-up points begin a new stroke without drawing.

Parameters:
- FIFO_DEPTH, 8, number of buffered points; power of two, minimum 2.
- H_ACTIVE, 800, horizontal active pixels; x is clamped to H_ACTIVE-1.
- V_ACTIVE, 480, vertical active lines; y is clamped to V_ACTIVE-1.
- TIMEOUT, 2000000, watchdog limit in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pt_valid  in  1  point offered.
- pt_x  in  11  point x coordinate.
- pt_y  in  10  point y coordinate.
- pt_pen_up  in  1  point starts a new stroke; no segment is drawn into it.
- pt_ready  out  1  FIFO not full.
- x_offset  out  11  segment start x, to drawer.
- y_offset  out  10  segment start y.
- x_final  out  11  segment end x.
- y_final  out  10  segment end y.
- start_mark  out  1  one-cycle segment start pulse.
- done_mark  in  1  drawer finished the segment.
- busy  out  1  segment in flight (START or WAIT state).
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy.
- seg_error  out  1  sticky watchdog flag (optional feature).

Behaviour:
- Reset values: all outputs 0 except pt_ready=1. State is IDLE, FIFO is empty, last_valid=0, last_x/last_y=0.
- Push: a point is accepted when pt_valid && pt_ready on a rising clk edge.
  - Coordinates are clamped on entry: x>H_ACTIVE-1 becomes H_ACTIVE-1; y>V_ACTIVE-1 becomes V_ACTIVE-1.
  - When the FIFO is full, pt_ready=0 and the point is not stored; the source must hold it.
- Pop happens only in IDLE when the FIFO is not empty. A push and a pop in the same cycle leave fifo_level unchanged. Pointers wrap modulo FIFO_DEPTH.
- State machine:
  - IDLE: pops the head point P.
    - If P.pen_up=1 or last_valid=0: last<=P, last_valid<=1, stay in IDLE, no segment.
    - Else if P equals last (degenerate): no segment, last<=P, stay in IDLE.
    - Else: x_offset/y_offset<=last, x_final/y_final<=P, last<=P, go to START.
  - START: start_mark=1 for exactly this one cycle, then go to WAIT.
  - WAIT: hold all four coordinates stable; on done_mark=1 go to IDLE.
- done_mark is sampled only in WAIT. If it is asserted during START or IDLE, it is ignored.
- Latency: a point accepted into an empty FIFO with last_valid=1 produces start_mark 2 cycles after acceptance (accept edge N, pop at N+1, start_mark high during cycle N+2).
- Back-to-back segments: the next pop may occur in the cycle after done_mark. The end point of one segment is the start point of the next.
- busy=1 in START and WAIT.
- Reset mid-segment: returns immediately to IDLE, empties the FIFO and clears last_valid. The drawer is not notified; the drawer shares the same reset.

Optional Feature:
- Macro LINESEQ_WATCHDOG_EN.
- Defined:
  - A counter runs in WAIT.
  - If it reaches TIMEOUT without done_mark, the FSM forces IDLE and sets seg_error=1 (sticky until reset).
  - The point is kept as last.
- Undefined: seg_error is tied to 0, there is no counter, and WAIT lasts indefinitely.

Decomposition:
- Shared package line_pkg: point_t struct {x[10:0], y[9:0], pen_up}, H_ACTIVE/V_ACTIVE defaults, and seq_state_t enum {IDLE, START, WAIT}.
- One sub-module: point_fifo, a parameterized synchronous FIFO of point_t with full/empty/level.
- Clamping, the last-point register and the FSM stay in the top level.

Test Plan:
- Push (15,0,pen_up=1) then (10,9,0); drawer returns done_mark 20 cycles after start -> one start_mark with x_offset=15, y_offset=0, x_final=10, y_final=9; coordinates held until done_mark.
- Push 3 points (3,0,1),(12,4,0),(20,20,0) back-to-back -> two segments, (3,0)->(12,4) then (12,4)->(20,20); second start_mark ≥1 cycle after the first done_mark.
- Hold done_mark low and push 10 points -> pt_ready drops when fifo_level=8; no point is lost after release; segment order is preserved.
- Push (900,600,0) after (0,0,1) -> x_final=799, y_final=479.
- Repeat the identical point (5,5,0) after (5,5,1) -> no start_mark. Assert done_mark during START -> ignored, FSM still waits.
- Assert reset during WAIT -> outputs return to 0, fifo_level=0; the next non-pen-up point draws nothing. With LINESEQ_WATCHDOG_EN and TIMEOUT=50, no done_mark -> seg_error=1 at cycle 50 of WAIT and FSM back in IDLE.
